mu0_serial_alu_ctrl: RTL
========================

# mu0_serial_alu_ctrl

Bit-serial ALU controller for the MU0 datapath. It accepts a 16-bit operation request and drives a single `alu1bit` slice for WIDTH cycles, LSB first. It holds the ripple carry in a flip-flop between cycles and assembles the result in a shift register. It sits between the MU0 control unit and the accumulator write path, and trades 16 slices of ripple logic for one slice plus sequencing.

## Interface
- `WIDTH`, 16, operand/result width in bits; must be ≥ 2.
- `clk`, input, 1, system clock; all state updates on the rising edge.
- `reset`, input, 1, synchronous, active-high; also drives the slice's `reset` input.
- `start`, input, 1, request strobe; sampled only when `ready`=1.
- `op`, input, 2, operation code: 00 ADD (A+B), 01 SUB (A−B), 10 PASSB (B), 11 INCA (A+1).
- `a`, input, WIDTH, operand A; sampled with `start`.
- `b`, input, WIDTH, operand B; sampled with `start`.
- `ready`, output, 1, controller is idle and can accept `start`.
- `busy`, output, 1, a serial operation is in progress.
- `done`, output, 1, single-cycle pulse; `result` and flags are valid.
- `result`, output, WIDTH, operation result; held until the next accepted `start` or `reset`.
- `flag_z`, output, 1, result is zero.
- `flag_n`, output, 1, result MSB.
- `flag_c`, output, 1, final carry out (SUB: 1 = no borrow).

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DONE when the bit counter reaches WIDTH−1.
  - DONE → IDLE unconditionally.
- Accept: in IDLE with `start`=1, latch `a` and `b` into shift registers. INCA latches B as 0.
- On accept, also:
  - Load the carry flip-flop with cin0: ADD 0, SUB 1, PASSB 0, INCA 1.
  - Clear the counter and `result`.
- Slice controls, held constant for the whole operation:
  - `aen` = 0 for PASSB, else 1.
  - `binv` = 1 for SUB only.
- Each RUN cycle:
  - Slice inputs: `a` = A[0], `b` = B[0], `cin` = carry FF.
  - A and B shift right by one.
  - `result` shifts right with slice `sum` entering at the MSB.
  - Carry FF captures `cout`.
  - Counter increments.
- After WIDTH RUN cycles, `result` bit i equals the slice `sum` from cycle i.
- Flags are registered on entry to DONE and held with `result`:
  - `flag_z` is computed on the final result, including the last bit.
  - `flag_n` = `result[WIDTH-1]`.
  - `flag_c` = final carry.
- Counter width is clog2(WIDTH); it does not wrap inside an operation.
- `start` while `busy` or in DONE is ignored. There is no queueing.
- `op`, `a` and `b` are ignored except in the accept cycle.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0, all flags 0, carry FF 0, counter 0.
- `start` accepted at edge 0 → `busy`=1 for edges 1..WIDTH → `done`=1 for one cycle after edge WIDTH+1 → `ready`=1 after edge WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- `ready` = (state==IDLE); `busy` = (state==RUN); `done` = (state==DONE). All three are registered-state decodes with no combinational path from inputs.
- `reset` asserted mid-RUN or in DONE:
  - At the next edge, return to IDLE with all reset values.
  - The partial result is discarded and `done` is not pulsed.
- `reset` and `start` asserted together: reset wins and the request is dropped.

## Configuration
- `MU0_SERIAL_ALU_FLAGS_EN`:
  - Defined: `flag_z`, `flag_n` and `flag_c` are registered as above.
  - Undefined: the three flag outputs are tied to 0, the flag registers and the zero-detect logic are removed, and ports stay present.
- `result`, the handshake and the latency are identical in both builds.

## Structure
- Shared package `mu0_alu_pkg`:
  - op codes as a 2-bit enum (`OP_ADD`, `OP_SUB`, `OP_PASSB`, `OP_INCA`).
  - state enum (`S_IDLE`, `S_RUN`, `S_DONE`).
  - `MU0_WIDTH` = 16.
- One sub-module: the existing `alu1bit` slice, instantiated once as `u_slice`. No other hierarchy.

## Test plan
- ADD a=0x1234, b=0x0FF1 → `result`=0x2225, Z=0, N=0, C=0; `done` pulses exactly 17 edges after accept.
- SUB a=0x0005, b=0x0005 → `result`=0x0000, Z=1, N=0, C=1.
- ADD a=0xFFFF, b=0x0001 → `result`=0x0000, Z=1, C=1.
- SUB a=0x0003, b=0x0005 → `result`=0xFFFE, N=1, C=0. Then INCA a=0x7FFF → `result`=0x8000, N=1, C=0.
- PASSB a=0x1111, b=0xABCD → `result`=0xABCD. A second `start` at RUN cycle 5 with b=0x0000 is ignored, and `result` is still 0xABCD.
- Reset at RUN cycle 8 of ADD 0x00FF+0x0001 → next cycle `ready`=1, `result`=0, no `done` pulse. A following ADD 0x00FF+0x0001 → 0x0100.

Source files
------------

// File: rtl/mu0_alu_pkg.sv
// Shared types for the MU0 bit-serial ALU: op codes, controller states, default width.
package mu0_alu_pkg;

  localparam int MU0_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_PASSB = 2'b10,
    OP_INCA  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Carry-in for bit 0: SUB completes the two's complement, INCA supplies the +1.
  function automatic logic op_cin0(op_t o);
    return (o == OP_SUB) || (o == OP_INCA);
  endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice: full adder with A gating and B inversion; outputs forced low in reset.
module alu1bit (
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic aen,
  input  logic binv,
  output logic sum,
  output logic cout
);

  logic a_eff;
  logic b_eff;

  assign a_eff = a & aen;
  assign b_eff = b ^ binv;

  always_comb begin
    sum  = 1'b0;
    cout = 1'b0;
    if (!reset) begin
      sum  = a_eff ^ b_eff ^ cin;
      cout = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
    end
  end

endmodule

// File: rtl/mu0_serial_alu_ctrl.sv
// Bit-serial MU0 ALU controller: one alu1bit slice sequenced LSB first over WIDTH cycles.
// Define MU0_SERIAL_ALU_FLAGS_EN to register Z/N/C flags; otherwise they are tied low.
module mu0_serial_alu_ctrl
  import mu0_alu_pkg::*;
#(
  parameter int WIDTH = MU0_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             aen_q, aen_d;
  logic             binv_q, binv_d;
  logic             sum;
  logic             cout;
  logic             accept;
  logic             last_bit;
  op_t              op_in;

  assign op_in    = op_t'(op);
  assign accept   = (state_q == S_IDLE) && start;
  assign last_bit = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

  alu1bit u_slice (
    .reset (reset),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .aen   (aen_q),
    .binv  (binv_q),
    .sum   (sum),
    .cout  (cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    aen_d   = aen_q;
    binv_d  = binv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = (op_in == OP_INCA) ? '0 : b;
          carry_d = op_cin0(op_in);
          aen_d   = (op_in != OP_PASSB);
          binv_d  = (op_in == OP_SUB);
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {sum, res_q[WIDTH-1:1]};
        carry_d = cout;
        // Counter stops at WIDTH-1 so it never wraps inside an operation.
        if (last_bit) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      aen_q   <= 1'b0;
      binv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      aen_q   <= aen_d;
      binv_q  <= binv_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = res_q;

`ifdef MU0_SERIAL_ALU_FLAGS_EN
  logic fz_q, fz_d;
  logic fn_q, fn_d;
  logic fc_q, fc_d;

  // Flags see the final bit directly from the slice, i.e. the result being written this edge.
  always_comb begin
    fz_d = fz_q;
    fn_d = fn_q;
    fc_d = fc_q;
    if (accept) begin
      fz_d = 1'b0;
      fn_d = 1'b0;
      fc_d = 1'b0;
    end else if (last_bit) begin
      fz_d = (res_d == '0);
      fn_d = sum;
      fc_d = cout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      fc_q <= 1'b0;
    end else begin
      fz_q <= fz_d;
      fn_q <= fn_d;
      fc_q <= fc_d;
    end
  end

  assign flag_z = fz_q;
  assign flag_n = fn_q;
  assign flag_c = fc_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule
